// File: rtl/mor1kx_fifo_fwft_sclk_pkg.sv
// Shared types and defaults for the single-clock FWFT FIFO.
package mor1kx_fifo_fwft_sclk_pkg;

   localparam int unsigned DefAddrWidth = 4;
   localparam int unsigned DefDataWidth = 32;

   // Occupancy update selected by the qualified handshakes {pop, push}.
   typedef enum logic [1:0] {
      OpHold = 2'b00,
      OpPush = 2'b01,
      OpPop  = 2'b10,
      OpBoth = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e decode_op(input logic push, input logic pop);
      return fifo_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/mor1kx_fifo_fwft_sclk_if.sv
// Producer/consumer handshake and status bundle of the FWFT FIFO.
interface mor1kx_fifo_fwft_sclk_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  flush;
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;

   // FIFO side.
   modport slave (
      input  flush, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, count, full, empty, almost_full
   );

   // Environment side (producer, consumer and status observer).
   modport master (
      output flush, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, count, full, empty, almost_full
   );

endinterface

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Simple dual-port RAM, one clock, registered read with optional write-to-read bypass.
module mor1kx_simple_dpram_sclk #(
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter string       ENABLE_BYPASS = "TRUE"
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int unsigned Depth  = 1 << ADDR_WIDTH;
   localparam bit          Bypass = (ENABLE_BYPASS == "TRUE");

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] dout_q;

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= din;
   end

   // Registered read; a same-cycle write to the read address returns the new data.
   always_ff @(posedge clk) begin
      if (re) dout_q <= (Bypass && we && (waddr == raddr)) ? din : mem_q[raddr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/mor1kx_fifo_fwft_sclk.sv
// Single-clock first-word-fall-through FIFO built on a bypassed registered-read RAM.
module mor1kx_fifo_fwft_sclk
   import mor1kx_fifo_fwft_sclk_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
   parameter int unsigned DATA_WIDTH  = DefDataWidth,
   parameter int unsigned ALMOST_FULL = (1 << ADDR_WIDTH) - 1
) (
   input logic                    clk,
   input logic                    rst_n,
   mor1kx_fifo_fwft_sclk_if.slave bus
);

   localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AfLevel  = (ADDR_WIDTH + 1)'(ALMOST_FULL);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  push, pop, full, empty;
   logic [ADDR_WIDTH-1:0] raddr;
   fifo_op_e              op;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);

   // flush outranks both handshakes, so it also suppresses the RAM write.
   assign push = bus.s_valid & ~full & ~bus.flush;
   assign pop  = ~empty & bus.m_ready & ~bus.flush;
   assign op   = decode_op(push, pop);

   // Look one entry ahead on a pop so the registered RAM output tracks the next head.
   assign raddr = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      unique case (op)
         OpPush: begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q + (ADDR_WIDTH + 1)'(1);
         end
         OpPop: begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q - (ADDR_WIDTH + 1)'(1);
         end
         OpBoth: begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         end
         OpHold: ;
         default: ;
      endcase
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   mor1kx_simple_dpram_sclk #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .ENABLE_BYPASS ("TRUE")
   ) u_ram (
      .clk   (clk),
      .raddr (raddr),
      .re    (1'b1),
      .waddr (wr_ptr_q),
      .we    (push),
      .din   (bus.s_data),
      .dout  (bus.m_data)
   );

   // Status outputs depend on registered state only.
   assign bus.count       = count_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.s_ready     = ~full;
   assign bus.m_valid     = ~empty;
   assign bus.almost_full = (count_q >= AfLevel);

endmodule

// File: tb/tb_mor1kx_fifo_fwft_sclk.sv
// Directed self-checking bench for the FWFT FIFO (capacity 4).
module tb_mor1kx_fifo_fwft_sclk;

   localparam int unsigned Aw = 2;
   localparam int unsigned Dw = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mor1kx_fifo_fwft_sclk_if #(.ADDR_WIDTH(Aw), .DATA_WIDTH(Dw)) bus ();

   mor1kx_fifo_fwft_sclk #(
      .ADDR_WIDTH (Aw),
      .DATA_WIDTH (Dw)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      bus.flush   = 1'b0;
   endtask

   task automatic push1(input logic [31:0] d);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.m_ready = 1'b0;
      step();
      bus.s_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_q [4];
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.s_data = '0;
      idle();
      step();
      step();

      // Reset values
      chk("rst_empty", 64'(bus.empty), 64'd1);
      chk("rst_full", 64'(bus.full), 64'd0);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_almost_full", 64'(bus.almost_full), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      rst_n = 1'b1;
      step();

      // 1: single push falls through next cycle
      push1(32'hA5A5_0001);
      chk("t1_m_valid", 64'(bus.m_valid), 64'd1);
      chk("t1_m_data", 64'(bus.m_data), 64'hA5A5_0001);
      chk("t1_count", 64'(bus.count), 64'd1);
      chk("t1_empty", 64'(bus.empty), 64'd0);
      bus.m_ready = 1'b1;
      step();
      bus.m_ready = 1'b0;
      chk("t1_empty_after_pop", 64'(bus.empty), 64'd1);

      // 2: fill to capacity, hold a rejected push, then drain in order
      exp_q[0] = 32'h11; exp_q[1] = 32'h22; exp_q[2] = 32'h33; exp_q[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         push1(exp_q[i]);
         chk("t2_fill_count", 64'(bus.count), 64'(i + 1));
      end
      chk("t2_full", 64'(bus.full), 64'd1);
      chk("t2_s_ready", 64'(bus.s_ready), 64'd0);
      chk("t2_almost_full", 64'(bus.almost_full), 64'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h55;
      step();
      step();
      bus.s_valid = 1'b0;
      chk("t2_hold_count", 64'(bus.count), 64'd4);
      chk("t2_head_kept", 64'(bus.m_data), 64'h11);
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_data", 64'(bus.m_data), 64'(exp_q[i]));
         step();
         if (i == 0) begin
            chk("t2_full_drop", 64'(bus.full), 64'd0);
            chk("t2_s_ready_rise", 64'(bus.s_ready), 64'd1);
         end
      end
      bus.m_ready = 1'b0;
      chk("t2_empty", 64'(bus.empty), 64'd1);

      // 3: sustained push+pop at count 1 across several pointer wraps
      push1(32'h100);
      for (int i = 0; i < 12; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h101 + 32'(i);
         bus.m_ready = 1'b1;
         chk("t3_stream_data", 64'(bus.m_data), 64'(32'h100 + 32'(i)));
         step();
         chk("t3_stream_count", 64'(bus.count), 64'd1);
      end
      bus.s_valid = 1'b0;
      chk("t3_last_data", 64'(bus.m_data), 64'h10C);
      step();
      bus.m_ready = 1'b0;
      chk("t3_empty", 64'(bus.empty), 64'd1);

      // 4: pop and push at count 1 hits the RAM bypass
      push1(32'h77);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h88;
      bus.m_ready = 1'b1;
      step();
      idle();
      chk("t4_m_valid", 64'(bus.m_valid), 64'd1);
      chk("t4_m_data", 64'(bus.m_data), 64'h88);
      chk("t4_count", 64'(bus.count), 64'd1);
      bus.m_ready = 1'b1;
      step();
      idle();

      // 5: flush beats concurrent push and pop
      push1(32'hA1);
      push1(32'hA2);
      push1(32'hA3);
      chk("t5_pre_count", 64'(bus.count), 64'd3);
      bus.flush   = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hEE;
      bus.m_ready = 1'b1;
      step();
      idle();
      chk("t5_count", 64'(bus.count), 64'd0);
      chk("t5_m_valid", 64'(bus.m_valid), 64'd0);
      chk("t5_s_ready", 64'(bus.s_ready), 64'd1);
      push1(32'h99);
      chk("t5_new_head", 64'(bus.m_data), 64'h99);
      chk("t5_new_count", 64'(bus.count), 64'd1);
      bus.m_ready = 1'b1;
      step();
      idle();

      // 6: asynchronous reset mid-traffic
      push1(32'hB1);
      push1(32'hB2);
      chk("t6_pre_count", 64'(bus.count), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_count", 64'(bus.count), 64'd0);
      chk("t6_async_m_valid", 64'(bus.m_valid), 64'd0);
      chk("t6_async_empty", 64'(bus.empty), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("t6_post_m_valid", 64'(bus.m_valid), 64'd0);
      push1(32'hC3);
      chk("t6_push_m_valid", 64'(bus.m_valid), 64'd1);
      chk("t6_push_data", 64'(bus.m_data), 64'hC3);
      chk("t6_push_count", 64'(bus.count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
